rs_latch_sequencer: RTL and testbench
=====================================

# rs_latch_sequencer

Synchronous command sequencer that drives the R/S/E inputs of the gated RS latch and reads back its Q/Q_L outputs. It accepts set/reset/hold commands over a valid/ready handshake, generates a safe setup -> enable-pulse -> hold waveform, samples the latch through a 2-flop synchronizer and reports pass/fail per command. It is the initiator side of the latch interface and sits between the lab's control logic (or a bench) and the latch instance.

## Interface
- SETUP_CYC, 2, cycles R/S are stable with E=0 before the enable pulse (legal >= 1)
- PULSE_CYC, 3, cycles E is held high (legal >= 1)
- SETTLE_CYC, 2, cycles after the pulse before Q/Q_L is judged (legal >= 1)
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- cmd_valid  input  1  command present
- cmd_op  input  2  00 hold, 01 set, 10 reset, 11 illegal
- cmd_ready  output  1  sequencer can accept a command
- resp_valid  output  1  response present
- resp_ready  input  1  response consumed
- resp_ok  output  1  latch state matched expectation
- resp_q  output  1  synchronized Q sampled at judge time
- R  output  1  latch reset input
- S  output  1  latch set input
- E  output  1  latch enable
- Q  input  1  latch output (asynchronous to clk)
- Q_L  input  1  latch complementary output (asynchronous to clk)

## Operation
- States: IDLE, SETUP, PULSE, HOLD, SETTLE, RESP. One down-counter (width fits max parameter) shared across timed states.
- IDLE: cmd_ready=1, R=S=E=0. Accept on cmd_valid&&cmd_ready; latch cmd_op into op register.
- Op 11: go straight to RESP with resp_ok=0, resp_q=current sync Q; R/S/E never driven; known-state tracker unchanged.
- Op 00/01/10 -> SETUP: S=(op==01), R=(op==10), E=0 for SETUP_CYC cycles.
- PULSE: same R/S, E=1 for PULSE_CYC cycles.
- HOLD: 1 cycle, E=0, R/S still held (hold time); then R=S=0.
- SETTLE: R=S=E=0 for SETTLE_CYC cycles; on the last SETTLE cycle capture sync Q/Q_L into resp_q and compute resp_ok.
- Expected Q: set -> 1; reset -> 0; hold -> known_q if known_valid, else any value. resp_ok = (qs != qls) && (qs == expected or expectation is "any").
- Tracker: after set/reset with resp_ok=1, known_q<=expected, known_valid<=1; a failed set/reset clears known_valid. Hold never changes tracker.
- RESP: resp_valid=1, resp_ok/resp_q stable until resp_valid&&resp_ready, then IDLE. cmd_ready=0 in every state except IDLE.
- R and S are never both 1 (structural guarantee, not a check).
- Synchronizer: two flops each on Q and Q_L, reset to 0; judge uses second stage only.

## Timing
- Reset (async assert, sync-safe deassert use): state IDLE, cmd_ready=1 from first cycle after deassert, resp_valid=0, resp_ok=0, resp_q=0, R=S=E=0, known_valid=0, sync flops 0. Reset mid-sequence drops E/R/S immediately (combinationally with rst_n low).
- Command accepted at edge 0 -> R/S visible after edge 0; E rises after edge SETUP_CYC, falls after edge SETUP_CYC+PULSE_CYC; R/S fall one edge later.
- resp_valid rises after edge SETUP_CYC+PULSE_CYC+SETTLE_CYC+1 (defaults: edge 8). Illegal op: resp_valid after edge 1.
- Back-to-back: earliest next accept is the edge after the response handshake edge (one IDLE cycle minimum).
- resp_ready held high in RESP: handshake completes on the first RESP edge.
- cmd_valid while busy: ignored, no side effect; command must be held by source.

## Test plan
- Reset then set (op 01), latch model correct -> S=1 edges 0-6, E=1 after edges 2-4, resp_valid at edge 8 with resp_ok=1, resp_q=1.
- Reset command after set -> R pulse, resp_ok=1, resp_q=0; following hold -> R=S=0 throughout, E pulses, resp_ok=1, resp_q=0.
- Hold immediately after reset (tracker unknown) with Q=1,Q_L=0 -> resp_ok=1; with Q=Q_L=1 forced -> resp_ok=0.
- Op 11 -> R/S/E stay 0, resp_valid after edge 1, resp_ok=0; tracker unchanged (subsequent hold still checks old known_q).
- Stuck latch (Q forced 0) then set -> resp_ok=0, resp_q=0, known_valid cleared; resp_ready held low 5 cycles -> resp_valid/resp_ok stable, cmd_ready=0, new cmd_valid ignored.
- rst_n pulsed low during PULSE -> E/S drop same cycle, resp_valid=0, cmd_ready=1 after release, no response emitted for aborted command.

Source files
------------

// File: rtl/rs_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rs_latch_sequencer
// Purpose  : Initiator for a gated RS latch. It accepts hold/set/reset
//            commands over a valid/ready handshake. For each command it
//            drives a setup -> enable-pulse -> hold -> settle waveform on
//            R/S/E. It then samples Q/Q_L through a 2-flop synchronizer and
//            returns a pass/fail response.
// Ports    : clk, rst_n           - clock, async active-low reset
//            cmd_valid/cmd_ready - command handshake, cmd_op (00 hold,
//                                  01 set, 10 reset, 11 illegal)
//            resp_valid/resp_ready - response handshake, resp_ok, resp_q
//            R, S, E             - latch drive (registered)
//            Q, Q_L              - latch readback (asynchronous to clk)
// Revision : 1.0 - initial release
// ============================================================================
module rs_latch_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_ok,
  output logic       resp_q,
  output logic       R,
  output logic       S,
  output logic       E,
  input  logic       Q,
  input  logic       Q_L
);

  localparam logic [1:0] C_OP_HOLD    = 2'b00;
  localparam logic [1:0] C_OP_SET     = 2'b01;
  localparam logic [1:0] C_OP_RESET   = 2'b10;
  localparam logic [1:0] C_OP_ILLEGAL = 2'b11;

  localparam int C_MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int C_MAX_CYC = (C_MAX_AB > SETTLE_CYC) ? C_MAX_AB : SETTLE_CYC;
  // The counter holds (cycles - 1), so it only has to reach C_MAX_CYC-1.
  localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [1:0]         r_op;
  logic               r_known_q;
  logic               r_known_valid;
  logic               r_q_s1, r_q_s2;
  logic               r_ql_s1, r_ql_s2;

  // Judge logic: only the second synchronizer stage is looked at.
  logic w_exp_any;
  logic w_exp_q;
  logic w_ok;
  logic w_is_setrst;

  always_comb begin
    w_is_setrst = (r_op == C_OP_SET) || (r_op == C_OP_RESET);
    w_exp_any   = (r_op == C_OP_HOLD) && !r_known_valid;
    w_exp_q     = (r_op == C_OP_SET)   ? 1'b1 :
                  (r_op == C_OP_RESET) ? 1'b0 : r_known_q;
    w_ok        = (r_op != C_OP_ILLEGAL) && (r_q_s2 != r_ql_s2) &&
                  (w_exp_any || (r_q_s2 == w_exp_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_op          <= C_OP_HOLD;
      r_known_q     <= 1'b0;
      r_known_valid <= 1'b0;
      r_q_s1        <= 1'b0;
      r_q_s2        <= 1'b0;
      r_ql_s1       <= 1'b0;
      r_ql_s2       <= 1'b0;
      cmd_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_ok       <= 1'b0;
      resp_q        <= 1'b0;
      R             <= 1'b0;
      S             <= 1'b0;
      E             <= 1'b0;
    end else begin
      r_q_s1  <= Q;
      r_q_s2  <= r_q_s1;
      r_ql_s1 <= Q_L;
      r_ql_s2 <= r_ql_s1;

      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op      <= cmd_op;
            cmd_ready <= 1'b0;
            if (cmd_op == C_OP_ILLEGAL) begin
              // An illegal op skips the latch entirely. It passes through a
              // single zero-length settle cycle, which samples the current
              // synchronized Q and lands the response one edge later.
              r_state <= ST_SETTLE;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_SETUP;
              r_cnt   <= C_CNT_W'(SETUP_CYC - 1);
              // Decoded from a 2-bit op, so R and S can never both be 1.
              S       <= (cmd_op == C_OP_SET);
              R       <= (cmd_op == C_OP_RESET);
            end
          end
        end

        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= ST_PULSE;
            r_cnt   <= C_CNT_W'(PULSE_CYC - 1);
            E       <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_HOLD;
            E       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_HOLD: begin
          // R/S have been held one extra cycle past the falling edge of E.
          r_state <= ST_SETTLE;
          r_cnt   <= C_CNT_W'(SETTLE_CYC - 1);
          R       <= 1'b0;
          S       <= 1'b0;
        end

        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_q     <= r_q_s2;
            resp_ok    <= w_ok;
            // Only set/reset teach the tracker. A failure forgets the state.
            if (w_is_setrst) begin
              r_known_valid <= w_ok;
              if (w_ok) begin
                r_known_q <= w_exp_q;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            r_state    <= ST_IDLE;
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          cmd_ready  <= 1'b1;
          resp_valid <= 1'b0;
          R          <= 1'b0;
          S          <= 1'b0;
          E          <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_latch_sequencer
// Purpose  : Self-checking bench for rs_latch_sequencer. It contains a
//            behavioural gated RS latch with fault modes, and a reference
//            model of the expected waveform timing and responses.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_latch_sequencer;

  localparam int SETUP  = 2;
  localparam int PULSE  = 3;
  localparam int SETTLE = 2;
  localparam int SP     = SETUP + PULSE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_ok;
  logic       resp_q;
  logic       R, S, E;
  logic       Q, Q_L;

  int tests = 0;
  int fails = 0;

  // Latch model. The mode selects the fault:
  // 0 = healthy, 1 = Q stuck at 0, 2 = Q=Q_L=1, 3 = forced Q=1/Q_L=0.
  logic       lq = 1'b0;
  logic [1:0] mode = 2'd0;
  // Tracker for what the latch is known to hold.
  logic       tb_kv;
  logic       tb_kq;

  always @(E or S or R) begin
    if (E) begin
      if (S)      lq = 1'b1;
      else if (R) lq = 1'b0;
    end
  end

  assign Q   = (mode == 2'd0) ? lq  : (mode == 2'd1) ? 1'b0 : 1'b1;
  assign Q_L = (mode == 2'd0) ? ~lq : (mode == 2'd3) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  rs_latch_sequencer #(
    .SETUP_CYC (SETUP),
    .PULSE_CYC (PULSE),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_ok   (resp_ok),
    .resp_q    (resp_q),
    .R         (R),
    .S         (S),
    .E         (E),
    .Q         (Q),
    .Q_L       (Q_L)
  );

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One complete command: waveform per edge, response contents, stall
  // stability, then handshake and return to idle.
  task automatic run_cmd(input logic [1:0] op, input int stall);
    int   rv_edge;
    logic exp_s, exp_r, exp_e, exp_v;
    logic exp_any, exp_val, exp_ok, exp_q;
    bit   seen;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_cmd op=%0d: cmd_ready=%b expected 1", op, cmd_ready);
    end
    rv_edge = (op == 2'b11) ? 1 : SP + SETTLE + 1;
    seen = 1'b0;
    for (int e = 0; e <= rv_edge; e++) begin
      @(posedge clk);
      #1;
      exp_s = (op == 2'b01) && (e <= SP);
      exp_r = (op == 2'b10) && (e <= SP);
      exp_e = (op != 2'b11) && (e >= SETUP) && (e < SP);
      exp_v = (e == rv_edge);
      tests++;
      if ({R, S, E, resp_valid, cmd_ready} !== {exp_r, exp_s, exp_e, exp_v, 1'b0}) begin
        fails++;
        $display("FAIL wave op=%0d edge=%0d: R,S,E,valid,ready=%b%b%b%b%b expected %b%b%b%b0",
                 op, e, R, S, E, resp_valid, cmd_ready, exp_r, exp_s, exp_e, exp_v);
      end
      if (resp_valid === 1'b1) seen = 1'b1;
      // Busy-time noise on the command port must have no effect.
      if (e < rv_edge) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
      end else begin
        cmd_valid = 1'b0;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout op=%0d: resp_valid=%b expected 1", op, resp_valid);
    end

    // Expected response from the latch rules and the known-state tracker.
    if (op == 2'b11) begin
      exp_ok = 1'b0;
      exp_val = 1'b0;
    end else begin
      exp_any = (op == 2'b00) && !tb_kv;
      exp_val = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? 1'b0 : tb_kq;
      exp_ok  = (Q != Q_L) && (exp_any || (Q == exp_val));
    end
    exp_q = Q;
    tests++;
    if ({resp_ok, resp_q} !== {exp_ok, exp_q}) begin
      fails++;
      $display("FAIL resp op=%0d: ok,q=%b%b expected %b%b", op, resp_ok, resp_q, exp_ok, exp_q);
    end
    if (op == 2'b01 || op == 2'b10) begin
      tb_kv = exp_ok;
      if (exp_ok) tb_kq = exp_val;
    end

    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      tests++;
      if ({resp_valid, resp_ok, resp_q, cmd_ready, R, S, E} !== {1'b1, exp_ok, exp_q, 4'b0000}) begin
        fails++;
        $display("FAIL stall op=%0d cyc=%0d: valid,ok,q,ready,R,S,E=%b%b%b%b%b%b%b expected 1%b%b0000",
                 op, i, resp_valid, resp_ok, resp_q, cmd_ready, R, S, E, exp_ok, exp_q);
      end
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    tests++;
    if ({resp_valid, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL handshake op=%0d: valid,ready=%b%b expected 01", op, resp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    resp_ready = 1'b0;
    tb_kv      = 1'b0;
    tb_kq      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cmd_ready, resp_valid, resp_ok, resp_q, R, S, E} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_state: ready,valid,ok,q,R,S,E=%b%b%b%b%b%b%b expected 1000000",
               cmd_ready, resp_valid, resp_ok, resp_q, R, S, E);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({cmd_ready, resp_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: ready,valid=%b%b expected 10", cmd_ready, resp_valid);
    end
  endtask

  task automatic test_hold_unknown;
    set_mode(2'd3);
    run_cmd(2'b00, 0);   // any value accepted, Q/Q_L differ
    set_mode(2'd2);
    run_cmd(2'b00, 0);   // Q == Q_L must fail
    set_mode(2'd0);
  endtask

  task automatic test_set_reset_hold;
    run_cmd(2'b01, 0);
    run_cmd(2'b10, 0);
    run_cmd(2'b00, 0);
  endtask

  task automatic test_illegal;
    run_cmd(2'b11, 0);
    run_cmd(2'b00, 0);   // still judged against the old known_q
  endtask

  task automatic test_stuck;
    set_mode(2'd1);
    run_cmd(2'b01, 5);
    // Tracker is cleared, so a hold with Q=1 must now be accepted.
    set_mode(2'd3);
    run_cmd(2'b00, 0);
    set_mode(2'd0);
  endtask

  task automatic test_back_to_back;
    run_cmd(2'b01, 0);
    run_cmd(2'b00, 0);
    run_cmd(2'b10, 1);
    run_cmd(2'b00, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) set_mode(2'($urandom_range(0, 3)));
      else if (mode != 2'd0 && $urandom_range(0, 1) == 0) set_mode(2'd0);
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    set_mode(2'd0);
  endtask

  task automatic test_abort;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (SETUP + 1) @(posedge clk);
    #1;
    tests++;
    if ({S, E} !== 2'b11) begin
      fails++;
      $display("FAIL abort_pulse: S,E=%b%b expected 11", S, E);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({R, S, E, resp_valid, cmd_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL abort_drop: R,S,E,valid,ready=%b%b%b%b%b expected 00001",
               R, S, E, resp_valid, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb_kv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({R, S, E, resp_valid, cmd_ready} !== 5'b00001) begin
        fails++;
        $display("FAIL abort_quiet cyc=%0d: R,S,E,valid,ready=%b%b%b%b%b expected 00001",
                 i, R, S, E, resp_valid, cmd_ready);
      end
    end
    run_cmd(2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_hold_unknown();
    test_set_reset_hold();
    test_illegal();
    test_stuck();
    test_back_to_back();
    test_random();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
